accel_apb_ctrl: RTL and testbench



---
 rtl/accel_apb_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_accel_apb_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/accel_apb_ctrl.sv
//==============================================================================
// Module      : accel_apb_ctrl
// Description : APB4 host front end for the Keccak accelerator. It provides the
//               run-control registers and a word-addressed window onto RAM port a.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package accel_apb_pkg;
    typedef logic [3:0] acc_state_t;
    typedef logic [3:0] acc_error_t;
endpackage

module accel_apb_ctrl
    import accel_apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 13,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int MEM_DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        PSEL,
    input  logic                        PENABLE,
    input  logic                        PWRITE,
    input  logic [APB_ADDR_WIDTH-1:0]   PADDR,
    input  logic [MEM_DATA_WIDTH-1:0]   PWDATA,
    input  logic [MEM_DATA_WIDTH/8-1:0] PSTRB,
    output logic [MEM_DATA_WIDTH-1:0]   PRDATA,
    output logic                        PREADY,
    output logic                        PSLVERR,
    output logic                        start,
    input  logic                        done,
    output logic                        output_length_byte,
    input  acc_state_t                  accel_state,
    input  acc_error_t                  accel_error,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
    output logic [MEM_DATA_WIDTH/8-1:0] mem_be,
    output logic [MEM_DATA_WIDTH-1:0]   mem_wdata,
    input  logic [MEM_DATA_WIDTH-1:0]   mem_rdata,
    output logic                        irq
);

    localparam int                        c_OFF_W   = APB_ADDR_WIDTH - 3;
    localparam logic [c_OFF_W-1:0]        c_OFF_CTRL   = c_OFF_W'(0);
    localparam logic [c_OFF_W-1:0]        c_OFF_STATUS = c_OFF_W'(1);
    localparam logic [c_OFF_W-1:0]        c_OFF_IRQEN  = c_OFF_W'(2);
    localparam logic [c_OFF_W-1:0]        c_OFF_CYCLES = c_OFF_W'(3);
    localparam logic [MEM_DATA_WIDTH-1:0] c_CYC_ONE    = MEM_DATA_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

    state_t                      r_state;
    logic                        r_start;
    logic                        r_olb;
    logic                        r_done_flag;
    logic                        r_irq_en;
    logic [MEM_DATA_WIDTH-1:0]   r_cycles;

    logic                        w_access;
    logic                        w_win;
    logic [c_OFF_W-1:0]          w_offset;
    logic                        w_win_blocked;
    logic                        w_ram_go;
    logic                        w_reg_acc;
    logic                        w_reg_wr;
    logic                        w_ctrl_wr;
    logic                        w_ctrl_err;
    logic                        w_launch;
    logic                        w_status_w1c;
    logic                        w_irqen_wr;
    logic [MEM_DATA_WIDTH-1:0]   w_reg_rdata;
    logic                        w_unused;

    // New access phases are only decoded in IDLE; RD_WAIT finishes the read already in flight.
    assign w_access      = PSEL & PENABLE & (r_state == ST_IDLE);
    assign w_win         = PADDR[APB_ADDR_WIDTH-1];
    assign w_offset      = PADDR[APB_ADDR_WIDTH-2:2];
    assign w_win_blocked = w_access & w_win & r_start;
    assign w_ram_go      = w_access & w_win & ~r_start;
    assign w_reg_acc     = w_access & ~w_win;
    assign w_reg_wr      = w_reg_acc & PWRITE;
    assign w_ctrl_wr     = w_reg_wr & (w_offset == c_OFF_CTRL);
    assign w_ctrl_err    = w_ctrl_wr & r_start;
    assign w_launch      = w_ctrl_wr & ~r_start & PWDATA[0];
    assign w_status_w1c  = w_reg_wr & (w_offset == c_OFF_STATUS) & PWDATA[1];
    assign w_irqen_wr    = w_reg_wr & (w_offset == c_OFF_IRQEN);

    assign w_unused = ^{PADDR[1:0], PWDATA[MEM_DATA_WIDTH-1:2]};

    assign start              = r_start;
    assign output_length_byte = r_olb;
    assign irq                = r_done_flag & r_irq_en;

    assign mem_en    = w_ram_go;
    assign mem_we    = w_ram_go & PWRITE;
    assign mem_addr  = PADDR[MEM_ADDR_WIDTH+1:2];
    assign mem_wdata = PWDATA;
    assign mem_be    = PWRITE ? PSTRB : '1;

    always_comb begin
        w_reg_rdata = '0;
        case (w_offset)
            c_OFF_CTRL: begin
                w_reg_rdata[0] = r_start;
                w_reg_rdata[1] = r_olb;
            end
            c_OFF_STATUS: begin
                w_reg_rdata[0]                         = r_start;
                w_reg_rdata[1]                         = r_done_flag;
                w_reg_rdata[8 +: $bits(acc_state_t)]   = accel_state;
                w_reg_rdata[16 +: $bits(acc_error_t)]  = accel_error;
            end
            c_OFF_IRQEN:  w_reg_rdata[0] = r_irq_en;
            c_OFF_CYCLES: w_reg_rdata    = r_cycles;
            default:      w_reg_rdata    = '0;
        endcase
    end

    always_comb begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        if (r_state == ST_RD_WAIT) begin
            PREADY = 1'b1;
            PRDATA = mem_rdata;
        end else if (w_access) begin
            // A permitted RAM read is the only IDLE access that inserts a wait state.
            PREADY  = ~(w_ram_go & ~PWRITE);
            PSLVERR = w_win_blocked | w_ctrl_err;
            if (w_reg_acc && !PWRITE) begin
                PRDATA = w_reg_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_start     <= 1'b0;
            r_olb       <= 1'b0;
            r_done_flag <= 1'b0;
            r_irq_en    <= 1'b0;
            r_cycles    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ram_go && !PWRITE) begin
                        r_state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase

            if (r_start && (r_cycles != '1)) begin
                r_cycles <= r_cycles + c_CYC_ONE;
            end

            // The clear comes first so a run ending in the same cycle keeps the flag set.
            if (w_status_w1c) begin
                r_done_flag <= 1'b0;
            end
            if (r_start && done) begin
                r_start     <= 1'b0;
                r_done_flag <= 1'b1;
            end

            if (w_ctrl_wr && !r_start) begin
                r_olb <= PWDATA[1];
            end
            if (w_launch) begin
                r_start     <= 1'b1;
                r_cycles    <= '0;
                r_done_flag <= 1'b0;
            end

            if (w_irqen_wr) begin
                r_irq_en <= PWDATA[0];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_accel_apb_ctrl.sv
//==============================================================================
// Module      : tb_accel_apb_ctrl
// Description : Directed self-checking bench for accel_apb_ctrl with a RAM model.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_accel_apb_ctrl;
    import accel_apb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        PSEL, PENABLE, PWRITE;
    logic [12:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        start, done, output_length_byte;
    acc_state_t  accel_state;
    acc_error_t  accel_error;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        irq;

    logic [31:0] ram [0:1023];
    int          n_memen = 0;

    int          n_chk  = 0;
    int          n_pass = 0;

    logic [31:0] t_rdata;
    logic        t_err;
    int          t_waits;
    logic        t_en, t_we, t_setup_en;
    logic [9:0]  t_addr;

    always #5 clk = ~clk;

    accel_apb_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .PSEL               (PSEL),
        .PENABLE            (PENABLE),
        .PWRITE             (PWRITE),
        .PADDR              (PADDR),
        .PWDATA             (PWDATA),
        .PSTRB              (PSTRB),
        .PRDATA             (PRDATA),
        .PREADY             (PREADY),
        .PSLVERR            (PSLVERR),
        .start              (start),
        .done               (done),
        .output_length_byte (output_length_byte),
        .accel_state        (accel_state),
        .accel_error        (accel_error),
        .mem_en             (mem_en),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_be             (mem_be),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .irq                (irq)
    );

    // Port-a RAM: byte-enabled writes, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    always @(negedge clk) begin
        if (mem_en) n_memen <= n_memen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic apb(input logic wr, input logic [12:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
        @(negedge clk);
        t_setup_en = mem_en;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        t_waits = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                t_en = mem_en; t_we = mem_we; t_addr = mem_addr;
            end
            if (PREADY) begin
                t_rdata = PRDATA; t_err = PSLVERR; got = 1'b1;
                break;
            end
            t_waits++;
        end
        if (!got) check("apb_timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    initial begin
        int cnt_start, cnt_olb, memen_mark;
        rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0;
        PWDATA = '0; PSTRB = '0; done = 1'b0; accel_state = '0; accel_error = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_start", 32'(start), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_olb", 32'(output_length_byte), 32'd0);
        for (int i = 0; i < 4; i++) begin
            apb(1'b0, 13'(4 * i), 32'd0, 4'h0);
            check($sformatf("rst_reg%0d", i), t_rdata, 32'd0);
            check($sformatf("rst_err%0d", i), 32'(t_err), 32'd0);
        end
        apb(1'b0, 13'h010, 32'd0, 4'h0);
        check("unmapped_rd", t_rdata, 32'd0);
        check("unmapped_err", 32'(t_err), 32'd0);

        memen_mark = n_memen;
        apb(1'b1, 13'h1014, 32'hDEADBEEF, 4'hF);
        check("wr_setup_en", 32'(t_setup_en), 32'd0);
        check("wr_en", 32'(t_en), 32'd1);
        check("wr_we", 32'(t_we), 32'd1);
        check("wr_addr", 32'(t_addr), 32'd5);
        check("wr_waits", 32'(t_waits), 32'd0);
        check("wr_en_cycles", 32'(n_memen - memen_mark), 32'd1);
        apb(1'b0, 13'h1014, 32'd0, 4'h0);
        check("rd_en", 32'(t_en), 32'd1);
        check("rd_we", 32'(t_we), 32'd0);
        check("rd_waits", 32'(t_waits), 32'd1);
        check("rd_data", t_rdata, 32'hDEADBEEF);
        check("rd_en_cycles", 32'(n_memen - memen_mark), 32'd2);
        apb(1'b1, 13'h1014, 32'h12345678, 4'b0011);
        apb(1'b0, 13'h1014, 32'd0, 4'h0);
        check("strb_data", t_rdata, 32'hDEAD5678);

        // Run 1: OLB set, done after 20 cycles.
        accel_state = 4'h5; accel_error = 4'h1;
        apb(1'b1, 13'h008, 32'h1, 4'hF);
        apb(1'b1, 13'h000, 32'h3, 4'hF);
        check("launch_err", 32'(t_err), 32'd0);
        check("launch_start", 32'(start), 32'd1);
        cnt_start = 0; cnt_olb = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (start) cnt_start++;
            if (output_length_byte) cnt_olb++;
            if (k == 20) done = 1'b1;
        end
        @(posedge clk); #1 done = 1'b0;
        check("run_start_cycles", 32'(cnt_start), 32'd20);
        check("run_olb_cycles", 32'(cnt_olb), 32'd20);
        check("end_start", 32'(start), 32'd0);
        check("end_irq", 32'(irq), 32'd1);
        apb(1'b0, 13'h004, 32'd0, 4'h0);
        check("end_status", t_rdata, 32'h00010502);
        apb(1'b0, 13'h00C, 32'd0, 4'h0);
        check("end_cycles", t_rdata, 32'd20);
        apb(1'b0, 13'h000, 32'd0, 4'h0);
        check("end_ctrl", t_rdata, 32'h2);
        apb(1'b1, 13'h004, 32'h2, 4'hF);
        check("w1c_irq", 32'(irq), 32'd0);
        apb(1'b0, 13'h004, 32'd0, 4'h0);
        check("w1c_status", t_rdata, 32'h00010500);

        // Run 2: window and CTRL are blocked during a run.
        apb(1'b1, 13'h000, 32'h1, 4'hF);
        memen_mark = n_memen;
        apb(1'b0, 13'h1014, 32'd0, 4'h0);
        check("busy_rd_err", 32'(t_err), 32'd1);
        check("busy_rd_data", t_rdata, 32'd0);
        check("busy_rd_waits", 32'(t_waits), 32'd0);
        check("busy_rd_en", 32'(n_memen - memen_mark), 32'd0);
        apb(1'b1, 13'h000, 32'h0, 4'hF);
        check("busy_ctrl_err", 32'(t_err), 32'd1);
        check("busy_ctrl_start", 32'(start), 32'd1);
        apb(1'b0, 13'h000, 32'd0, 4'h0);
        check("busy_ctrl_rd", t_rdata, 32'h1);
        @(negedge clk) done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        check("run2_end_start", 32'(start), 32'd0);

        // Run 3: reset sampled at the 7th edge of the run.
        apb(1'b1, 13'h000, 32'h1, 4'hF);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 7) rst = 1'b1;
        end
        @(posedge clk); #1 rst = 1'b0;
        check("rst_run_start", 32'(start), 32'd0);
        apb(1'b0, 13'h00C, 32'd0, 4'h0);
        check("rst_run_cycles", t_rdata, 32'd0);
        @(negedge clk) done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        apb(1'b0, 13'h004, 32'd0, 4'h0);
        check("rst_late_done", t_rdata, 32'h00010500);
        apb(1'b0, 13'h008, 32'd0, 4'h0);
        check("rst_irqen", t_rdata, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
